// File: rtl/midori_masked_sbox_layer_ctrl_if.sv
// Signal bundle between the masked S-box layer controller, the round datapath
// and the shared pipelined masked S-box core.
interface midori_masked_sbox_layer_ctrl_if #(
  parameter int unsigned NNIB = 16
);
  localparam int unsigned SW = 4 * NNIB;

  logic          start;
  logic [SW-1:0] st_in1;
  logic [SW-1:0] st_in2;
  logic [SW-1:0] st_in3;
  logic [3:0]    sb_in1;
  logic [3:0]    sb_in2;
  logic [3:0]    sb_in3;
  logic [3:0]    sb_out1;
  logic [3:0]    sb_out2;
  logic [3:0]    sb_out3;
  logic [SW-1:0] st_out1;
  logic [SW-1:0] st_out2;
  logic [SW-1:0] st_out3;
  logic          busy;
  logic          done;

  modport master (
    input  start, st_in1, st_in2, st_in3, sb_out1, sb_out2, sb_out3,
    output sb_in1, sb_in2, sb_in3, st_out1, st_out2, st_out3, busy, done
  );

  modport slave (
    output start, st_in1, st_in2, st_in3, sb_out1, sb_out2, sb_out3,
    input  sb_in1, sb_in2, sb_in3, st_out1, st_out2, st_out3, busy, done
  );
endinterface

// File: rtl/midori_masked_sbox_layer_ctrl.sv
// Serialises a 3-share Midori state through an external pipelined masked S-box,
// one nibble per cycle, and reassembles the returned shares.
module midori_masked_sbox_layer_ctrl #(
  parameter int unsigned SBOX_LAT = 3,
  parameter int unsigned NNIB     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  midori_masked_sbox_layer_ctrl_if.master bus
);
  localparam int unsigned SW   = 4 * NNIB;
  localparam int unsigned CNTW = $clog2(NNIB) + 1;
  localparam int unsigned IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     rd_cnt, wr_cnt;
  logic [IDXW-1:0]     wr_idx;
  logic [SW-1:0]       sh1_q, sh2_q, sh3_q;
  logic [SW-1:0]       st_out1_q, st_out2_q, st_out3_q;
  logic [3:0]          sb_in1_q, sb_in2_q, sb_in3_q;
  logic [3:0]          sb_in1_d, sb_in2_d, sb_in3_d;
  logic [SBOX_LAT-1:0] vld_pipe;
  logic                busy_q, busy_d, done_q, done_d;
  logic                load_c, push_c, vld_out, feed_last, last_wr;

  assign vld_out   = vld_pipe[SBOX_LAT-1];
  assign feed_last = (rd_cnt == CNTW'(NNIB - 1));
  assign last_wr   = vld_out && (wr_cnt == CNTW'(NNIB - 1));
  assign wr_idx    = wr_cnt[IDXW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DRAIN leaves on the cycle the last nibble is written
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FEED;
      FEED:    if (feed_last) state_d = DRAIN;
      DRAIN:   if (last_wr)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; nibble k+1 is loaded while nibble k is on the bus
  always_comb begin
    load_c   = 1'b0;
    push_c   = 1'b0;
    sb_in1_d = '0;
    sb_in2_d = '0;
    sb_in3_d = '0;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_c   = 1'b1;
          sb_in1_d = bus.st_in1[3:0];
          sb_in2_d = bus.st_in2[3:0];
          sb_in3_d = bus.st_in3[3:0];
        end
      end
      FEED: begin
        push_c = 1'b1;
        if (!feed_last) begin
          sb_in1_d = sh1_q[3:0];
          sb_in2_d = sh2_q[3:0];
          sb_in3_d = sh3_q[3:0];
        end
      end
      default: ;
    endcase
  end

  // Per-share datapath: each share keeps its own register and write path
  always_ff @(posedge clk) begin
    if (rst) begin
      sh1_q     <= '0;
      sh2_q     <= '0;
      sh3_q     <= '0;
      st_out1_q <= '0;
      st_out2_q <= '0;
      st_out3_q <= '0;
      sb_in1_q  <= '0;
      sb_in2_q  <= '0;
      sb_in3_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      vld_pipe  <= '0;
    end else begin
      sb_in1_q    <= sb_in1_d;
      sb_in2_q    <= sb_in2_d;
      sb_in3_q    <= sb_in3_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vld_pipe[0] <= push_c;
      for (int i = 1; i < SBOX_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (load_c) begin
        sh1_q  <= bus.st_in1 >> 4;
        sh2_q  <= bus.st_in2 >> 4;
        sh3_q  <= bus.st_in3 >> 4;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (state_q == FEED) begin
          sh1_q <= sh1_q >> 4;
          sh2_q <= sh2_q >> 4;
          sh3_q <= sh3_q >> 4;
          if (!feed_last) rd_cnt <= rd_cnt + CNTW'(1);
        end
        if (vld_out) begin
          st_out1_q[4*wr_idx +: 4] <= bus.sb_out1;
          st_out2_q[4*wr_idx +: 4] <= bus.sb_out2;
          st_out3_q[4*wr_idx +: 4] <= bus.sb_out3;
          wr_cnt                   <= wr_cnt + CNTW'(1);
        end
      end
    end
  end

  assign bus.sb_in1  = sb_in1_q;
  assign bus.sb_in2  = sb_in2_q;
  assign bus.sb_in3  = sb_in3_q;
  assign bus.st_out1 = st_out1_q;
  assign bus.st_out2 = st_out2_q;
  assign bus.st_out3 = st_out3_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_midori_masked_sbox_layer_ctrl.sv
// Bench: a 3-cycle re-masking Midori S-box model on one controller and a
// 1-cycle identity stub on a second, checked against a nibble-wise substitution model.
module tb_midori_masked_sbox_layer_ctrl;
  localparam int unsigned NNIB   = 16;
  localparam int unsigned SW     = 4 * NNIB;
  localparam int unsigned LAT_A  = 3;
  localparam int unsigned LAT_B  = 1;
  localparam int          MAXCYC = 60;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  midori_masked_sbox_layer_ctrl_if #(.NNIB(NNIB)) a_if ();
  midori_masked_sbox_layer_ctrl_if #(.NNIB(NNIB)) b_if ();

  midori_masked_sbox_layer_ctrl #(.SBOX_LAT(LAT_A), .NNIB(NNIB)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.master));
  midori_masked_sbox_layer_ctrl #(.SBOX_LAT(LAT_B), .NNIB(NNIB)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.master));

  logic [3:0] sb_tab [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                              4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};

  function automatic logic [11:0] mask_sb(input logic [3:0] x, input logic [7:0] r);
    return {sb_tab[x] ^ r[7:4] ^ r[3:0], r[7:4], r[3:0]};
  endfunction

  function automatic logic [SW-1:0] model_sub(input logic [SW-1:0] x);
    logic [SW-1:0] r;
    logic [3:0]    nib;
    r = '0;
    for (int k = 0; k < NNIB; k++) begin
      nib        = x[4*k +: 4];
      r[4*k +: 4] = sb_tab[nib];
    end
    return r;
  endfunction

  // Masked S-box model with fresh output masks, LAT_A cycles deep
  logic [11:0] spipe [LAT_A];
  always @(posedge clk) begin
    spipe[0] <= mask_sb(a_if.sb_in1 ^ a_if.sb_in2 ^ a_if.sb_in3, 8'($urandom));
    for (int i = 1; i < LAT_A; i++) spipe[i] <= spipe[i-1];
  end
  assign a_if.sb_out1 = spipe[LAT_A-1][11:8];
  assign a_if.sb_out2 = spipe[LAT_A-1][7:4];
  assign a_if.sb_out3 = spipe[LAT_A-1][3:0];

  // Registered identity stub
  always @(posedge clk) begin
    b_if.sb_out1 <= b_if.sb_in1;
    b_if.sb_out2 <= b_if.sb_in2;
    b_if.sb_out3 <= b_if.sb_in3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                       input logic [SW-1:0] s3, input bit hold, input int extra,
                       output int done_cyc, output int n_done);
    int            exp_done;
    int            stop;
    logic [SW-1:0] expx;
    logic [SW-1:0] gotx;
    logic [3:0]    e1, e2, e3;
    exp_done     = NNIB + LAT_A + 1;
    expx         = model_sub(s1 ^ s2 ^ s3);
    a_if.st_in1  = s1;
    a_if.st_in2  = s2;
    a_if.st_in3  = s3;
    a_if.start   = 1'b1;
    tick();
    if (!hold) a_if.start = 1'b0;
    done_cyc = -1;
    n_done   = 0;
    stop     = MAXCYC;
    for (int i = 1; i <= stop; i++) begin
      if (i <= NNIB) begin
        e1 = s1[4*(i-1) +: 4];
        e2 = s2[4*(i-1) +: 4];
        e3 = s3[4*(i-1) +: 4];
      end else begin
        e1 = '0; e2 = '0; e3 = '0;
      end
      n_cmp++;
      if (a_if.sb_in1 !== e1 || a_if.sb_in2 !== e2 || a_if.sb_in3 !== e3) begin
        n_bad++;
        $display("FAIL sb_in cycle %0d: got %h/%h/%h want %h/%h/%h", i,
                 a_if.sb_in1, a_if.sb_in2, a_if.sb_in3, e1, e2, e3);
      end
      n_cmp++;
      if (a_if.busy !== 1'(i <= exp_done)) begin
        n_bad++;
        $display("FAIL busy cycle %0d: got %b want %b", i, a_if.busy, (i <= exp_done));
      end
      if (a_if.done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc   = i;
          stop       = i + extra;
          a_if.start = 1'b0;
        end
      end
      if (i < stop) tick();
    end
    a_if.start = 1'b0;
    n_cmp++;
    if (done_cyc != exp_done) begin
      n_bad++;
      $display("FAIL done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    n_cmp++;
    if (n_done != 1) begin
      n_bad++;
      $display("FAIL done_pulses: got %0d want 1", n_done);
    end
    gotx = a_if.st_out1 ^ a_if.st_out2 ^ a_if.st_out3;
    n_cmp++;
    if (gotx !== expx) begin
      n_bad++;
      $display("FAIL result: got %h want %h", gotx, expx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++;
    if (a_if.st_out1 !== '0 || a_if.st_out2 !== '0 || a_if.st_out3 !== '0 ||
        a_if.busy !== 1'b0 || a_if.done !== 1'b0 ||
        a_if.sb_in1 !== 4'h0 || a_if.sb_in2 !== 4'h0 || a_if.sb_in3 !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_a: got out %h/%h/%h busy %b done %b sb %h%h%h want all 0",
               a_if.st_out1, a_if.st_out2, a_if.st_out3, a_if.busy, a_if.done,
               a_if.sb_in1, a_if.sb_in2, a_if.sb_in3);
    end
    n_cmp++;
    if (b_if.st_out1 !== '0 || b_if.busy !== 1'b0 || b_if.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: got out1 %h busy %b done %b want 0", b_if.st_out1, b_if.busy, b_if.done);
    end
  endtask

  task automatic test_nominal();
    int dc, nd;
    logic [SW-1:0] gotx;
    run_a(64'h0123456789ABCDEF, '0, '0, 1'b0, 2, dc, nd);
    gotx = a_if.st_out1 ^ a_if.st_out2 ^ a_if.st_out3;
    n_cmp++;
    if (gotx !== 64'hCAD3EBF789150246) begin
      n_bad++;
      $display("FAIL nominal_const: got %h want cad3ebf789150246", gotx);
    end
  endtask

  task automatic test_random_masks();
    int dc, nd;
    logic [SW-1:0] m1, m2;
    for (int it = 0; it < 100; it++) begin
      m1 = {$urandom, $urandom};
      m2 = {$urandom, $urandom};
      run_a(64'h0123456789ABCDEF ^ m1 ^ m2, m1, m2, 1'b0, 1, dc, nd);
    end
  endtask

  task automatic test_start_held();
    int dc, nd;
    logic [SW-1:0] m1;
    m1 = {$urandom, $urandom};
    run_a(64'h0123456789ABCDEF ^ m1, m1, '0, 1'b1, 10, dc, nd);
  endtask

  task automatic test_mid_reset();
    int dc, nd;
    logic [SW-1:0] m1, m2;
    m1 = {$urandom, $urandom};
    m2 = {$urandom, $urandom};
    a_if.st_in1 = 64'h0123456789ABCDEF ^ m1;
    a_if.st_in2 = m1;
    a_if.st_in3 = '0;
    a_if.start  = 1'b1;
    tick();
    a_if.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (a_if.st_out1 !== '0 || a_if.st_out2 !== '0 || a_if.st_out3 !== '0 ||
        a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got out %h/%h/%h busy %b done %b want 0",
               a_if.st_out1, a_if.st_out2, a_if.st_out3, a_if.busy, a_if.done);
    end
    repeat (5) tick();
    n_cmp++;
    if (a_if.st_out1 !== '0 || a_if.st_out2 !== '0 || a_if.st_out3 !== '0) begin
      n_bad++;
      $display("FAIL stale_write: got %h/%h/%h want 0", a_if.st_out1, a_if.st_out2, a_if.st_out3);
    end
    run_a({SW{1'b1}} ^ m1 ^ m2, m1, m2, 1'b0, 2, dc, nd);
  endtask

  task automatic test_back_to_back();
    int dc, nd;
    run_a({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, dc, nd);
    tick();
    n_cmp++;
    if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_cycle: got busy %b done %b want 0 0", a_if.busy, a_if.done);
    end
    run_a({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2, dc, nd);
  endtask

  task automatic test_lat1();
    int dc;
    logic [SW-1:0] s1, s2, s3;
    for (int it = 0; it < 3; it++) begin
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      s3 = {$urandom, $urandom};
      b_if.st_in1 = s1;
      b_if.st_in2 = s2;
      b_if.st_in3 = s3;
      b_if.start  = 1'b1;
      tick();
      b_if.start = 1'b0;
      dc = -1;
      for (int i = 1; i <= MAXCYC; i++) begin
        if (b_if.done === 1'b1) begin
          dc = i;
          break;
        end
        tick();
      end
      n_cmp++;
      if (dc != int'(NNIB + LAT_B + 1)) begin
        n_bad++;
        $display("FAIL lat1_done_cycle: got %0d want %0d", dc, NNIB + LAT_B + 1);
      end
      n_cmp++;
      if (b_if.st_out1 !== s1 || b_if.st_out2 !== s2 || b_if.st_out3 !== s3) begin
        n_bad++;
        $display("FAIL lat1_identity: got %h/%h/%h want %h/%h/%h",
                 b_if.st_out1, b_if.st_out2, b_if.st_out3, s1, s2, s3);
      end
      tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    a_if.start  = 1'b0;
    a_if.st_in1 = '0;
    a_if.st_in2 = '0;
    a_if.st_in3 = '0;
    b_if.start  = 1'b0;
    b_if.st_in1 = '0;
    b_if.st_in2 = '0;
    b_if.st_in3 = '0;
    test_reset();
    test_nominal();
    test_random_masks();
    test_start_held();
    test_mid_reset();
    test_back_to_back();
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/midori_masked_sbox_layer_ctrl.md
Name: midori_masked_sbox_layer_ctrl

Overview:
- Initiator side of the 3-share, second-order masked Midori S-box interface.
- Accepts a full 64-bit Midori state in three Boolean shares and streams it one nibble per cycle into an external pipelined masked S-box instance.
- Tracks in-flight nibbles, collects the returned shares into a 64-bit output state, and signals completion.
- Sits between the round datapath and the shared S-box core in serialized encryption/decryption rounds.

Parameters:
- SBOX_LAT, 3, clock cycles from sb_in* being driven to the matching sb_out* being valid. Integer ≥ 1.
- NNIB, 16, nibbles per state; state width is 4*NNIB.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- st_in1  input  64  state share 1.
- st_in2  input  64  state share 2.
- st_in3  input  64  state share 3.
- sb_in1  output  4  nibble share 1 to S-box.
- sb_in2  output  4  nibble share 2 to S-box.
- sb_in3  output  4  nibble share 3 to S-box.
- sb_out1  input  4  S-box result share 1.
- sb_out2  input  4  S-box result share 2.
- sb_out3  input  4  S-box result share 3.
- st_out1  output  64  substituted state share 1.
- st_out2  output  64  substituted state share 2.
- st_out3  output  64  substituted state share 3.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all registered outputs are 0 (st_out*, busy, done, sb_in*). FSM goes to IDLE, counters are 0, and the valid pipe is cleared.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: on start=1, capture st_in1..3 into three separate 64-bit share registers. Clear rd_cnt and wr_cnt. Go to FEED.
- FEED: for rd_cnt = 0..NNIB-1, drive sb_inK = shareK[4*rd_cnt+3 : 4*rd_cnt], registered so that it is valid during the FEED cycle. Push 1 into the SBOX_LAT-deep valid pipe. After rd_cnt = NNIB-1, go to DRAIN.
- Outside FEED: sb_in* = 0 and 0 is pushed into the valid pipe.
- Collection: when the valid pipe's output is 1, write sb_outK into st_outK[4*wr_cnt+3 : 4*wr_cnt] and increment wr_cnt. This happens in any state, so with small SBOX_LAT it overlaps FEED.
- DRAIN: once wr_cnt reaches NNIB (last write done), go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. st_out* hold until the next accepted start.
- Timing: with start accepted at edge E0, nibble k is driven in cycle k+1 and captured at the end of cycle k+1+SBOX_LAT. done is high in cycle NNIB+SBOX_LAT+1, which is cycle 20 for the defaults.
- busy is high in FEED, DRAIN and DONE; it is low in IDLE.
- start while not IDLE is ignored, with no effect on counters or data.
- st_out* are overwritten progressively during a run. Consumers use them only after done.
- Reset mid-run: return to IDLE immediately and clear the valid pipe. Any results still inside the external S-box are discarded, never written.
- Share separation: shares are never XORed, multiplexed together or sharing a combinational path. Each share has its own register and mux chain. No share-dependent control.
- Width rules: rd_cnt and wr_cnt are clog2(NNIB)+1 bits; no wrap. The pipe length equals exactly SBOX_LAT.

Test Plan:
- Nominal, SBOX_LAT=3, real masked Midori S-box attached: shares (0x0123456789ABCDEF, 0, 0) → done in cycle 20 and st_out1^st_out2^st_out3 = 0xCAD3EBF789150246.
- Random masks: shares (X^m1^m2, m1, m2) with X=0x0123456789ABCDEF → same XOR result 0xCAD3EBF789150246, for 100 random (m1,m2) pairs.
- start held high during FEED/DRAIN → single run, exactly one done pulse, unchanged result.
- rst asserted in cycle 8 of a run, then start with X=0xFFFFFFFFFFFFFFFF → previous data never written, result 0x6666666666666666, st_out*=0 immediately after reset.
- Back-to-back: start in the cycle after done → second run accepted, busy low for exactly one cycle.
- SBOX_LAT=1 with a registered identity stub → st_out equals st_in share-wise, done in cycle 18.
